// File: rtl/riscv_pkg.sv
// Shared RV32I types and helpers for the decode stage.
//   opcode_t        : base opcode encodings
//   funct3_t/7_t    : function field types and the encodings the decoder checks
//   decoded_instr_t : decoded instruction plus pc and the two operand values
//   uses_rs1/rs2    : which opcodes actually read each source register
package riscv_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [6:0] {
        OP_LOAD    = 7'h03,
        OP_REG_IMM = 7'h13,
        OP_AUIPC   = 7'h17,
        OP_STORE   = 7'h23,
        OP_REG_REG = 7'h33,
        OP_LUI     = 7'h37,
        OP_BRANCH  = 7'h63,
        OP_JALR    = 7'h67,
        OP_JAL     = 7'h6F
    } opcode_t;

    typedef logic [2:0] funct3_t;
    typedef logic [6:0] funct7_t;

    localparam funct7_t FUNCT7_BASE = 7'h00;
    localparam funct7_t FUNCT7_ALT  = 7'h20;

    localparam funct3_t F3_ADD_SUB = 3'd0;
    localparam funct3_t F3_SLL     = 3'd1;
    localparam funct3_t F3_SRL_SRA = 3'd5;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        opcode_t               opcode;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        funct3_t               funct3;
        funct7_t               funct7;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] reg_A;
        logic [DATA_WIDTH-1:0] reg_B;
    } decoded_instr_t;

    function automatic logic uses_rs1(opcode_t op);
        case (op)
            OP_REG_REG, OP_REG_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(opcode_t op);
        case (op)
            OP_REG_REG, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_field_decoder.sv
// Combinational RV32I field/immediate decoder with illegal-instruction detection.
//   instr   in  : raw 32-bit instruction
//   pc      in  : instruction address, passed through into the decode
//   decoded out : fields and sign-extended immediate (reg_A/reg_B left zero);
//                 all fields except pc are zero for an illegal instruction
//   illegal out : instruction is not a supported RV32I encoding
module rv32i_field_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]            instr,
    input  logic [DATA_WIDTH-1:0]  pc,
    output decoded_instr_t         decoded,
    output logic                   illegal
);

    opcode_t               opcode;
    funct3_t               f3;
    funct7_t               f7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;

    always_comb begin
        opcode = opcode_t'(instr[6:0]);
        f3     = instr[14:12];
        f7     = instr[31:25];

        imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'h000};
        imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OP_REG_REG: begin
                // ALT encoding only exists for SUB and SRA
                if (!(f7 == FUNCT7_BASE ||
                      (f7 == FUNCT7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))))
                    illegal = 1'b1;
            end
            OP_REG_IMM: begin
                imm = imm_i;
                if (f3 == F3_SLL && f7 != FUNCT7_BASE)
                    illegal = 1'b1;
                if (f3 == F3_SRL_SRA && f7 != FUNCT7_BASE && f7 != FUNCT7_ALT)
                    illegal = 1'b1;
            end
            OP_LOAD: begin
                imm = imm_i;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)
                    illegal = 1'b1;
            end
            OP_STORE: begin
                imm = imm_s;
                if (f3 > 3'd2)
                    illegal = 1'b1;
            end
            OP_BRANCH: begin
                imm = imm_b;
                if (f3 == 3'd2 || f3 == 3'd3)
                    illegal = 1'b1;
            end
            OP_LUI, OP_AUIPC: imm = imm_u;
            OP_JAL:           imm = imm_j;
            OP_JALR: begin
                imm = imm_i;
                if (f3 != 3'd0)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        decoded = '0;
        if (!illegal) begin
            decoded.opcode = opcode;
            decoded.rd     = instr[11:7];
            decoded.rs1    = instr[19:15];
            decoded.rs2    = instr[24:20];
            decoded.funct3 = f3;
            decoded.funct7 = f7;
            decoded.imm    = imm;
        end
        decoded.pc = pc;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage between fetch and execute.
//   in_*            : fetch-side valid/ready handshake, instruction and pc
//   flush           : squash held and incoming instruction
//   rf_*            : register file read port (addresses combinational from in_instr)
//   wb_*            : writeback bypass into the operands
//   ex_is_load/ex_rd: load-use hazard detection against EX
//   out_*           : execute-side valid/ready handshake, decode and illegal flag
//   perf_stall_cnt  : saturating count of load-use stall cycles
module decode_stage_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ILEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          PERF_EN    = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ILEN-1:0]                    in_instr,
    input  logic [XLEN-1:0]                    in_pc,
    input  logic                               flush,
    output logic [REG_ADDR_W-1:0]              rf_rs1_addr,
    output logic [REG_ADDR_W-1:0]              rf_rs2_addr,
    input  logic [XLEN-1:0]                    rf_rs1_data,
    input  logic [XLEN-1:0]                    rf_rs2_data,
    input  logic                               wb_we,
    input  logic [REG_ADDR_W-1:0]              wb_rd,
    input  logic [XLEN-1:0]                    wb_data,
    input  logic                               ex_is_load,
    input  logic [REG_ADDR_W-1:0]              ex_rd,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$bits(decoded_instr_t)-1:0]  out_decoded,
    output logic                               out_illegal,
    output logic [31:0]                        perf_stall_cnt
);

    decoded_instr_t dec, dec_next, dec_q;
    logic           dec_illegal;
    logic           advance, hazard, transfer, stall_event;
    logic [REG_ADDR_W-1:0] rs1, rs2;

    rv32i_field_decoder u_field_decoder (
        .instr   (in_instr),
        .pc      (in_pc),
        .decoded (dec),
        .illegal (dec_illegal)
    );

    assign rf_rs1_addr = in_instr[15 +: REG_ADDR_W];
    assign rf_rs2_addr = in_instr[20 +: REG_ADDR_W];
    assign rs1 = rf_rs1_addr;
    assign rs2 = rf_rs2_addr;

    assign advance  = out_ready || !out_valid;
    assign hazard   = ex_is_load && (ex_rd != '0) &&
                      ((uses_rs1(dec.opcode) && ex_rd == rs1) ||
                       (uses_rs2(dec.opcode) && ex_rd == rs2));
    assign in_ready = advance && !hazard && !flush;
    assign transfer = in_valid && in_ready;
    assign stall_event = in_valid && hazard && !flush && advance;

    // Operand select keys off the decoded register fields, which are zero
    // for illegal instructions, so illegal decodes get zero operands too.
    always_comb begin
        dec_next = dec;
        if (dec.rs1 == '0)
            dec_next.reg_A = '0;
        else if (wb_we && wb_rd == dec.rs1)
            dec_next.reg_A = wb_data;
        else
            dec_next.reg_A = rf_rs1_data;

        if (dec.rs2 == '0)
            dec_next.reg_B = '0;
        else if (wb_we && wb_rd == dec.rs2)
            dec_next.reg_B = wb_data;
        else
            dec_next.reg_B = rf_rs2_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            dec_q       <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (transfer) begin
                out_valid   <= 1'b1;
                dec_q       <= dec_next;
                out_illegal <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_decoded = dec_q;

    generate
        if (PERF_EN) begin : g_perf
            logic [31:0] stall_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    stall_cnt <= '0;
                else if (stall_event && stall_cnt != '1)
                    stall_cnt <= stall_cnt + 32'd1;
            end
            assign perf_stall_cnt = stall_cnt;
        end else begin : g_no_perf
            assign perf_stall_cnt = '0;
        end
    endgenerate

endmodule
